// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the rv32i fetch port
// and its load/store port. Round-robin on contention, one access in flight,
// watchdog abort after TIMEOUT cycles without an acknowledge.
module mem_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction fetch side
  input  logic [31:0] i_addr,
  input  logic        i_rstrb,
  output logic [31:0] i_rdata,
  output logic        i_rbusy,
  // load/store side
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wmask,
  input  logic        d_wstrb,
  input  logic        d_rstrb,
  output logic [31:0] d_rdata,
  output logic        d_rbusy,
  output logic        d_wbusy,
  // downstream bus
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  // error reporting
  output logic        bus_err,
  input  logic        err_clr
);

  // The counter only has to reach TIMEOUT-1 before the abort decision.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_grant_q, last_grant_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wmask_q, wmask_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bus_err_q, bus_err_d;

  logic               i_pend;
  logic               d_pend;
  logic               grant;
  logic [31:0]        sel_addr;
  logic               err_set;

  assign i_pend = i_rstrb;
  assign d_pend = d_rstrb | d_wstrb;

  // State and latched transaction registers; everything clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      last_grant_q <= OWN_I;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      rdata_q      <= '0;
      cnt_q        <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      rdata_q      <= rdata_d;
      cnt_q        <= cnt_d;
      bus_err_q    <= bus_err_d;
    end
  end

  // Arbitration, issue/timeout sequencing and response capture.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    rdata_d      = rdata_q;
    cnt_d        = cnt_q;
    err_set      = 1'b0;
    grant        = OWN_I;
    sel_addr     = i_addr;

    case (state_q)
      IDLE: begin
        // On a tie the port that was not served last wins.
        if (i_pend && d_pend) begin
          grant = (last_grant_q == OWN_I) ? OWN_D : OWN_I;
        end else begin
          grant = d_pend ? OWN_D : OWN_I;
        end
        sel_addr = (grant == OWN_D) ? d_addr : i_addr;
        if (i_pend || d_pend) begin
          owner_d = grant;
          // Both load and store strobes together is treated as a store.
          we_d    = (grant == OWN_D) && d_wstrb;
          addr_d  = sel_addr & 32'hFFFF_FFFC;
          wdata_d = we_d ? d_wdata : 32'h0;
          wmask_d = we_d ? d_wmask : 4'b0000;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // An ack in the final watchdog cycle still counts as a completion.
        if (mem_ack) begin
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
          last_grant_d = owner_q;
          state_d      = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = ERR_DATA;
          err_set = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A timeout in the same cycle as a clear leaves the flag set.
    bus_err_d = bus_err_q;
    if (err_clr) begin
      bus_err_d = 1'b0;
    end
    if (err_set) begin
      bus_err_d = 1'b1;
    end
  end

  assign mem_req   = (state_q == ISSUE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
  assign bus_err   = bus_err_q;

  assign i_rdata = rdata_q;
  assign d_rdata = rdata_q;

  // Busy is released only for the owner during its response cycle.
  assign i_rbusy = i_rstrb && !((state_q == RESP) && (owner_q == OWN_I));
  assign d_rbusy = d_rstrb && !((state_q == RESP) && (owner_q == OWN_D) && !we_q);
  assign d_wbusy = d_wstrb && !((state_q == RESP) && (owner_q == OWN_D) && we_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a short watchdog (TIMEOUT=4).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_rstrb = 1'b0;
  logic [31:0] i_rdata;
  logic        i_rbusy;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_wmask = '0;
  logic        d_wstrb = 1'b0;
  logic        d_rstrb = 1'b0;
  logic [31:0] d_rdata;
  logic        d_rbusy;
  logic        d_wbusy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        bus_err;
  logic        err_clr = 1'b0;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  mem_arbiter #(
    .TIMEOUT (4),
    .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_addr   (i_addr),
    .i_rstrb  (i_rstrb),
    .i_rdata  (i_rdata),
    .i_rbusy  (i_rbusy),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_wmask  (d_wmask),
    .d_wstrb  (d_wstrb),
    .d_rstrb  (d_rstrb),
    .d_rdata  (d_rdata),
    .d_rbusy  (d_rbusy),
    .d_wbusy  (d_wbusy),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .bus_err  (bus_err),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic own_d;
    logic [31:0] rd;

    // Reset state
    #2;
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wmask", {28'b0, mem_wmask}, 32'h0);
    chk("rst_bus_err", {31'b0, bus_err}, 32'h0);
    chk("rst_rdata", i_rdata, 32'h0);
    chk("rst_i_rbusy_idle", {31'b0, i_rbusy}, 32'h0);
    d_rstrb = 1'b1;
    #1;
    chk("rst_d_rbusy_follows", {31'b0, d_rbusy}, 32'h1);
    d_rstrb = 1'b0;
    #10;
    rst_n = 1'b1;
    nxt();

    // Single fetch, ack in cycle 2
    i_rstrb = 1'b1;
    i_addr  = 32'h100;
    #1;
    chk("f_c0_busy", {31'b0, i_rbusy}, 32'h1);
    chk("f_c0_req", {31'b0, mem_req}, 32'h0);
    nxt();
    chk("f_c1_req", {31'b0, mem_req}, 32'h1);
    chk("f_c1_addr", mem_addr, 32'h100);
    chk("f_c1_we", {31'b0, mem_we}, 32'h0);
    chk("f_c1_busy", {31'b0, i_rbusy}, 32'h1);
    nxt();
    mem_ack = 1'b1;
    mem_rdata = 32'h0000_0013;
    #1;
    chk("f_c2_req", {31'b0, mem_req}, 32'h1);
    chk("f_c2_busy", {31'b0, i_rbusy}, 32'h1);
    nxt();
    mem_ack = 1'b0;
    #1;
    chk("f_c3_busy", {31'b0, i_rbusy}, 32'h0);
    chk("f_c3_rdata", i_rdata, 32'h0000_0013);
    i_rstrb = 1'b0;
    nxt();

    // Store with mask, immediate ack
    d_wstrb = 1'b1;
    d_addr  = 32'h203;
    d_wmask = 4'b1000;
    d_wdata = 32'hAAAA_AAAA;
    #1;
    chk("s_c0_wbusy", {31'b0, d_wbusy}, 32'h1);
    nxt();
    mem_ack = 1'b1;
    mem_rdata = 32'h9999_9999;
    #1;
    chk("s_c1_req", {31'b0, mem_req}, 32'h1);
    chk("s_c1_addr", mem_addr, 32'h200);
    chk("s_c1_we", {31'b0, mem_we}, 32'h1);
    chk("s_c1_wmask", {28'b0, mem_wmask}, 32'h8);
    chk("s_c1_wdata", mem_wdata, 32'hAAAA_AAAA);
    chk("s_c1_wbusy", {31'b0, d_wbusy}, 32'h1);
    nxt();
    mem_ack = 1'b0;
    #1;
    chk("s_c2_wbusy", {31'b0, d_wbusy}, 32'h0);
    chk("s_c2_rdata_kept", d_rdata, 32'h0000_0013);
    d_wstrb = 1'b0;
    d_wmask = 4'b0000;
    nxt();

    // Contention after a fresh reset: D, I, D, I
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    i_rstrb = 1'b1;
    d_rstrb = 1'b1;
    i_addr  = 32'h300;
    d_addr  = 32'h404;
    #1;
    chk("c_c0_ibusy", {31'b0, i_rbusy}, 32'h1);
    chk("c_c0_dbusy", {31'b0, d_rbusy}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      own_d = ((k % 2) == 0);
      rd = 32'h100 + k;
      nxt();
      mem_ack = 1'b1;
      mem_rdata = rd;
      #1;
      chk("c_issue_addr", mem_addr, own_d ? 32'h404 : 32'h300);
      chk("c_issue_wmask", {28'b0, mem_wmask}, 32'h0);
      chk("c_issue_ibusy", {31'b0, i_rbusy}, 32'h1);
      chk("c_issue_dbusy", {31'b0, d_rbusy}, 32'h1);
      nxt();
      mem_ack = 1'b0;
      #1;
      chk("c_resp_ibusy", {31'b0, i_rbusy}, own_d ? 32'h1 : 32'h0);
      chk("c_resp_dbusy", {31'b0, d_rbusy}, own_d ? 32'h0 : 32'h1);
      chk("c_resp_rdata", own_d ? d_rdata : i_rdata, rd);
      if (k == 3) begin
        i_rstrb = 1'b0;
        d_rstrb = 1'b0;
      end
      nxt();
      chk("c_idle_req", {31'b0, mem_req}, 32'h0);
    end

    // Timeout on a load with no ack
    d_rstrb = 1'b1;
    d_addr  = 32'h500;
    #1;
    for (int k = 0; k < 4; k++) begin
      nxt();
      chk("t_req_high", {31'b0, mem_req}, 32'h1);
      chk("t_dbusy", {31'b0, d_rbusy}, 32'h1);
    end
    nxt();
    chk("t_req_low", {31'b0, mem_req}, 32'h0);
    chk("t_resp_dbusy", {31'b0, d_rbusy}, 32'h0);
    chk("t_resp_rdata", d_rdata, 32'hDEADBEEF);
    chk("t_bus_err", {31'b0, bus_err}, 32'h1);
    d_rstrb = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'h1234_5678;
    nxt();
    chk("t_late_ack_req", {31'b0, mem_req}, 32'h0);
    mem_ack = 1'b0;
    nxt();
    chk("t_late_ack_idle", {31'b0, mem_req}, 32'h0);
    chk("t_late_ack_rdata", d_rdata, 32'hDEADBEEF);
    chk("t_err_sticky", {31'b0, bus_err}, 32'h1);
    err_clr = 1'b1;
    nxt();
    err_clr = 1'b0;
    #1;
    chk("t_err_cleared", {31'b0, bus_err}, 32'h0);

    // Timeout coinciding with err_clr: set wins
    d_rstrb = 1'b1;
    d_addr  = 32'h504;
    #1;
    for (int k = 0; k < 4; k++) begin
      nxt();
      if (k == 3) err_clr = 1'b1;
      #1;
      chk("t2_req_high", {31'b0, mem_req}, 32'h1);
    end
    nxt();
    err_clr = 1'b0;
    #1;
    chk("t2_set_wins", {31'b0, bus_err}, 32'h1);
    chk("t2_dbusy", {31'b0, d_rbusy}, 32'h0);
    d_rstrb = 1'b0;
    nxt();

    // Reset mid-ISSUE, fetch re-issued after release
    i_rstrb = 1'b1;
    i_addr  = 32'h600;
    nxt();
    chk("r_issue_req", {31'b0, mem_req}, 32'h1);
    chk("r_issue_err", {31'b0, bus_err}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("r_async_req", {31'b0, mem_req}, 32'h0);
    chk("r_async_err", {31'b0, bus_err}, 32'h0);
    chk("r_async_addr", mem_addr, 32'h0);
    chk("r_async_ibusy", {31'b0, i_rbusy}, 32'h1);
    nxt();
    rst_n = 1'b1;
    #1;
    chk("r_rel_idle", {31'b0, mem_req}, 32'h0);
    nxt();
    chk("r_reissue_req", {31'b0, mem_req}, 32'h1);
    chk("r_reissue_addr", mem_addr, 32'h600);
    mem_ack = 1'b1;
    mem_rdata = 32'h77;
    nxt();
    mem_ack = 1'b0;
    #1;
    chk("r_resp_ibusy", {31'b0, i_rbusy}, 32'h0);
    chk("r_resp_rdata", i_rdata, 32'h77);
    i_rstrb = 1'b0;
    nxt();

    // Strobe dropped mid-ISSUE, then a normal D load
    i_rstrb = 1'b1;
    i_addr  = 32'h700;
    nxt();
    i_rstrb = 1'b0;
    #1;
    chk("x_c1_req", {31'b0, mem_req}, 32'h1);
    chk("x_c1_ibusy", {31'b0, i_rbusy}, 32'h0);
    nxt();
    chk("x_c2_req", {31'b0, mem_req}, 32'h1);
    chk("x_c2_addr", mem_addr, 32'h700);
    nxt();
    mem_ack = 1'b1;
    mem_rdata = 32'h55;
    #1;
    chk("x_c3_req", {31'b0, mem_req}, 32'h1);
    nxt();
    mem_ack = 1'b0;
    #1;
    chk("x_resp_req", {31'b0, mem_req}, 32'h0);
    chk("x_resp_ibusy", {31'b0, i_rbusy}, 32'h0);
    chk("x_resp_dbusy", {31'b0, d_rbusy}, 32'h0);
    chk("x_resp_wbusy", {31'b0, d_wbusy}, 32'h0);
    d_rstrb = 1'b1;
    d_addr  = 32'h800;
    #1;
    chk("x_resp_dbusy_new", {31'b0, d_rbusy}, 32'h1);
    nxt();
    chk("x_idle_req", {31'b0, mem_req}, 32'h0);
    chk("x_idle_dbusy", {31'b0, d_rbusy}, 32'h1);
    nxt();
    mem_ack = 1'b1;
    mem_rdata = 32'h66;
    #1;
    chk("x_d_addr", mem_addr, 32'h800);
    chk("x_d_we", {31'b0, mem_we}, 32'h0);
    chk("x_d_wmask", {28'b0, mem_wmask}, 32'h0);
    nxt();
    mem_ack = 1'b0;
    #1;
    chk("x_d_resp_busy", {31'b0, d_rbusy}, 32'h0);
    chk("x_d_resp_rdata", d_rdata, 32'h66);
    chk("x_d_resp_ibusy", {31'b0, i_rbusy}, 32'h0);
    d_rstrb = 1'b0;
    nxt();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported memory between the rv32i instruction fetch port and its load/store port.
- Presents the core's strobe/busy interface on both requester sides.
- Drives one downstream req/ack bus and serialises accesses, with round-robin on contention and a watchdog timeout.
- Sits between the core and the unified RAM/peripheral bus in the SoC top.

Parameters:
TIMEOUT, 255, cycles in ISSUE without mem_ack before the arbiter aborts the access (>=1)
ERR_DATA, 32'hDEADBEEF, read data returned on a timed-out read

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
i_addr  in  32  instruction fetch address
i_rstrb  in  1  fetch request, level, held until !i_rbusy
i_rdata  out  32  fetched word, valid when i_rstrb && !i_rbusy
i_rbusy  out  1  fetch stall
d_addr  in  32  load/store byte address
d_wdata  in  32  store data (lanes pre-replicated by core)
d_wmask  in  4  store byte enables
d_wstrb  in  1  store request, level
d_rstrb  in  1  load request, level
d_rdata  out  32  load word, valid when d_rstrb && !d_rbusy
d_rbusy  out  1  load stall
d_wbusy  out  1  store stall
mem_req  out  1  downstream request, held with stable fields until mem_ack
mem_we  out  1  1 = write
mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
mem_wdata  out  32  write data
mem_wmask  out  4  byte enables (4'b0000 on reads)
mem_ack  in  1  one-cycle completion; mem_rdata valid same cycle on reads
mem_rdata  in  32  read data
bus_err  out  1  sticky timeout flag
err_clr  in  1  synchronous clear of bus_err

Behaviour:
- FSM states: IDLE, ISSUE, RESP.
- Pending requests: i_pend = i_rstrb; d_pend = d_rstrb | d_wstrb.
- IDLE:
  - If any request is pending, latch the grant (owner I or D), address, data, mask and we into registers, then go to ISSUE.
  - If both are pending, grant the port that was not granted last. last_grant resets to I, so D wins the first tie.
  - If neither is pending, stay in IDLE.
- d_wstrb and d_rstrb together is illegal; treat it as a write.
- ISSUE:
  - mem_req=1 with latched fields; the timeout counter increments each cycle.
  - On mem_ack: capture mem_rdata (reads only), go to RESP, update last_grant.
  - If the counter reaches TIMEOUT without an ack: capture ERR_DATA, set bus_err, deassert mem_req, go to RESP.
  - Once the counter hits TIMEOUT, a later ack is ignored.
- RESP:
  - Lasts exactly one cycle, then IDLE.
  - The owner's busy is 0 and its rdata is the captured register.
- Busy outputs are combinational:
  - i_rbusy = i_rstrb && !(state==RESP && owner==I).
  - d_rbusy = d_rstrb && !(RESP && owner==D && !we).
  - d_wbusy = d_wstrb && !(RESP && owner==D && we).
  - Busy is 0 whenever the corresponding strobe is low.
- i_rdata and d_rdata are both driven from the single capture register; the value is only meaningful to the owner in RESP.
- Latency: strobe rises in cycle 0 (IDLE) -> mem_req in cycle 1 -> ack in cycle N>=1 -> RESP (busy low) in cycle N+1. The minimum access is 3 cycles.
- No back-to-back RESP->ISSUE: a request still pending after RESP is re-arbitrated from IDLE.
- mem_ack outside ISSUE is ignored.
- Strobe dropped mid-ISSUE: the downstream transaction still completes; the response is discarded and the FSM returns to IDLE. No cancellation of mem_req.
- bus_err: set on timeout, cleared by err_clr. Set wins when both occur in the same cycle.
- Reset (async, any state, including mid-ISSUE):
  - state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wmask=0.
  - Capture register=0, counter=0, bus_err=0, last_grant=I.
  - Busy outputs then follow the strobes (stall any live request).

Test Plan:
- Single fetch: i_rstrb=1, i_addr=0x100; mem_ack in cycle 2 with mem_rdata=0x00000013 -> mem_req=1 in cycles 1-2 with mem_addr=0x100, mem_we=0; i_rbusy=1 in cycles 0-2; i_rbusy=0 and i_rdata=0x13 in cycle 3.
- Store with mask: d_wstrb=1, d_addr=0x203, d_wmask=4'b1000, d_wdata=0xAAAAAAAA, immediate ack -> mem_addr=0x200, mem_we=1, mem_wmask=4'b1000, mem_wdata=0xAAAAAAAA; d_wbusy low only in cycle 2.
- Contention: i_rstrb and d_rstrb asserted together after reset and held, every access acked immediately -> grant order D, I, D, I; the non-owner's busy stays 1 until its own RESP.
- Timeout: TIMEOUT=4, load with no ack -> mem_req high 4 cycles then low; d_rdata=0xDEADBEEF with d_rbusy=0 for one cycle; bus_err=1 until err_clr pulses; a late mem_ack has no effect.
- Reset mid-ISSUE: rst_n low while mem_req=1 -> mem_req=0 immediately (async), bus_err=0; after release the held i_rstrb is re-issued from IDLE.
- Dropped strobe: i_rstrb deasserted in cycle 1 of ISSUE, ack in cycle 3 -> FSM passes RESP then IDLE; no busy glitch on either port; the next d request is served normally.
